fetch_pair_queue: RTL and testbench
===================================

Name: fetch_pair_queue

Overview:
- Instruction fetch queue between the instruction cache/fetch unit and dual-issue decode of the SuperScalar core.
- Accepts up to two sequential instructions per cycle from fetch.
- Buffers them in a circular FIFO.
- Presents the two oldest entries, with their PCs, to issue slots 0 and 1 (the PC0/PC1 lanes); decode retires 0, 1 or 2 per cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- DW, 32, instruction width.
- AW, 32, PC width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries (branch redirect).
- in_valid  input  1  fetch offers a bundle this cycle.
- in_count  input  2  instructions in bundle: 1 or 2; 0 and 3 are illegal.
- in_pc  input  AW  PC of in_instr0.
- in_instr0  input  DW  first instruction.
- in_instr1  input  DW  second instruction; PC is in_pc+4.
- in_ready  output  1  queue can accept a full bundle.
- out_valid0  output  1  slot 0 holds an instruction.
- out_pc0  output  AW  PC of slot 0.
- out_instr0  output  DW  instruction of slot 0.
- out_valid1  output  1  slot 1 holds an instruction.
- out_pc1  output  AW  PC of slot 1.
- out_instr1  output  DW  instruction of slot 1.
- out_take  input  2  entries consumed by decode this cycle: 0..2.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- stall_cycles  output  32  empty-queue counter (see Optional Feature).

Behaviour:
- Storage: DEPTH entries of {pc, instr}.
  - Read pointer rd and write pointer wr, each $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - count register, $clog2(DEPTH)+1 bits.
- in_ready = (DEPTH - count) >= 2, combinational from registered count only; independent of out_take this cycle.
- Enqueue when in_valid && in_ready && !flush:
  - writes in_count entries at wr, wr+1.
  - second entry pc = in_pc + 4, modulo 2^AW.
  - wr advances by in_count.
- in_valid while !in_ready: bundle ignored, no state change; fetch must hold it.
- Outputs are combinational reads of entries rd and rd+1:
  - out_valid0 = count >= 1; out_valid1 = count >= 2.
  - Data on an invalid slot is don't-care.
- Dequeue: eff = min(out_take, count); rd advances by eff.
  - out_take exceeding count is clamped, not an error.
  - out_take = 2 with only slot 0 valid consumes one.
- Enqueue and dequeue in the same cycle: count_next = count + enq - eff.
  - Enqueue never overwrites a slot being read; in_ready is based on pre-dequeue count.
- flush: rd, wr, count <= 0 next edge.
  - Overrides same-cycle enqueue and dequeue.
  - Outputs show empty from the following cycle.
- Reset (async assert, synchronous-edge release): rd = wr = count = 0; stall_cycles = 0.
  - Therefore out_valid0 = out_valid1 = 0, occupancy = 0, in_ready = 1.
  - Storage contents are not reset.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Full (count = DEPTH) and count = DEPTH-1: in_ready = 0.
- Latency: an enqueued instruction is visible on out_* the cycle after the enqueue edge. There is no bypass.

Optional Feature:
- FETCHQ_STALL_CNT_EN defined:
  - stall_cycles increments by 1 each cycle with count == 0 and !flush && !rst.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by rst.
- Undefined: stall_cycles tied to 32'h0; no counter register synthesized.

Test Plan:
- Reset:
  - Stimulus: hold rst 7 ns, then release.
  - Response: out_valid0 = out_valid1 = 0, in_ready = 1, occupancy = 0.
- Two-wide fill:
  - Stimulus: bundles at in_pc = 0x00, 0x08, 0x10, 0x18 with count 2, out_take = 0.
  - Response: occupancy reaches 8, in_ready = 0 after the 4th bundle; slot 0 PC 0x00, slot 1 PC 0x04.
  - Follow-up: a 5th bundle is ignored until out_take = 2.
- Simultaneous enqueue/dequeue:
  - Stimulus: at count = 3, enqueue 2 (pc 0x40) with out_take = 2.
  - Response: count = 3; next slot 0 is the old third entry; slot 1 pc = 0x40.
- Clamp and wrap:
  - Stimulus: count = 1, out_take = 2.
  - Response: count = 0.
  - Follow-up: run 20 alternating enq 2 / take 2 cycles; PCs come out in strict +4 order across pointer wrap.
- Flush priority:
  - Stimulus: count = 5, flush = 1 together with in_valid = 1 and out_take = 1.
  - Response: next cycle count = 0, out_valid0 = 0; the in-flight bundle is not stored.
- Stall counter:
  - Stimulus: with FETCHQ_STALL_CNT_EN, idle 10 cycles after reset.
  - Response: stall_cycles = 10.
  - Without the macro: stall_cycles stays 0.

Source files
------------

// File: rtl/fetch_pair_queue_if.sv
// fetch_pair_queue_if: fetch-side and decode-side signals of the fetch pair queue.
// master = fetch/decode environment, slave = the queue.
interface fetch_pair_queue_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 32
);
    logic                     flush;
    logic                     in_valid;
    logic [1:0]               in_count;
    logic [AW-1:0]            in_pc;
    logic [DW-1:0]            in_instr0;
    logic [DW-1:0]            in_instr1;
    logic                     in_ready;
    logic                     out_valid0;
    logic [AW-1:0]            out_pc0;
    logic [DW-1:0]            out_instr0;
    logic                     out_valid1;
    logic [AW-1:0]            out_pc1;
    logic [DW-1:0]            out_instr1;
    logic [1:0]               out_take;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [31:0]              stall_cycles;

    modport master (
        output flush, in_valid, in_count, in_pc, in_instr0, in_instr1, out_take,
        input  in_ready, out_valid0, out_pc0, out_instr0, out_valid1, out_pc1, out_instr1,
               occupancy, stall_cycles
    );

    modport slave (
        input  flush, in_valid, in_count, in_pc, in_instr0, in_instr1, out_take,
        output in_ready, out_valid0, out_pc0, out_instr0, out_valid1, out_pc1, out_instr1,
               occupancy, stall_cycles
    );
endinterface

// File: rtl/fetch_pair_queue.sv
// fetch_pair_queue: two-in/two-out circular instruction queue between fetch and dual-issue decode.
// Define FETCHQ_STALL_CNT_EN to build the saturating empty-queue cycle counter.
module fetch_pair_queue #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input logic              clk,
    input logic              rst,
    fetch_pair_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_q    [DEPTH];
    logic [DW-1:0] instr_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd1, wr1;
    logic [CW-1:0] count_q, count_d, enq, take, eff;
    logic          enq_en;

    // Readiness uses the pre-dequeue count so a write can never land on a slot being read.
    assign bus.in_ready = count_q <= CW'(DEPTH - 2);

    always_comb begin
        enq_en  = bus.in_valid && bus.in_ready && !bus.flush;
        enq     = enq_en ? CW'(bus.in_count) : '0;
        take    = CW'(bus.out_take);
        eff     = (take > count_q) ? count_q : take;
        rd1     = rd_q + PW'(1);
        wr1     = wr_q + PW'(1);
        rd_d    = bus.flush ? '0 : rd_q + eff[PW-1:0];
        wr_d    = bus.flush ? '0 : wr_q + enq[PW-1:0];
        count_d = bus.flush ? '0 : count_q + enq - eff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_en) begin
            pc_q[wr_q]    <= bus.in_pc;
            instr_q[wr_q] <= bus.in_instr0;
            if (bus.in_count == 2'd2) begin
                pc_q[wr1]    <= bus.in_pc + AW'(4);
                instr_q[wr1] <= bus.in_instr1;
            end
        end
    end

    assign bus.out_valid0 = count_q >= CW'(1);
    assign bus.out_valid1 = count_q >= CW'(2);
    assign bus.out_pc0    = pc_q[rd_q];
    assign bus.out_instr0 = instr_q[rd_q];
    assign bus.out_pc1    = pc_q[rd1];
    assign bus.out_instr1 = instr_q[rd1];
    assign bus.occupancy  = count_q;

`ifdef FETCHQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = (count_q == '0 && !bus.flush && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_pair_queue.sv
// tb_fetch_pair_queue: directed vector table plus hand sequences for wrap, flush, async reset
// and the stall counter of fetch_pair_queue.
module tb_fetch_pair_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef FETCHQ_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd10;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    typedef struct {
        logic        v;
        logic [1:0]  c;
        logic [31:0] pc;
        logic [1:0]  take;
        logic [3:0]  occ;
        logic        v0;
        logic        v1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vt [16];

    fetch_pair_queue_if #(.DEPTH(8), .DW(32), .AW(32)) bus ();

    fetch_pair_queue #(.DEPTH(8), .DW(32), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] pc,
                         input logic [1:0] take, input logic fl);
        bus.in_valid  = v;
        bus.in_count  = c;
        bus.in_pc     = pc;
        bus.in_instr0 = pc ^ K;
        bus.in_instr1 = (pc + 32'd4) ^ K;
        bus.out_take  = take;
        bus.flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] nxt;
        drive(1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
        #7 rst = 1'b0;
        #1;
        chk("rst_v0", 64'(bus.out_valid0), 64'd0);
        chk("rst_v1", 64'(bus.out_valid1), 64'd0);
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_stall", 64'(bus.stall_cycles), 64'd0);
        step();

        vt[0]  = '{1'b1, 2'd2, 32'h00, 2'd0, 4'd2, 1'b1, 1'b1, 32'h00, 32'h04, 1'b1};
        vt[1]  = '{1'b1, 2'd2, 32'h08, 2'd0, 4'd4, 1'b1, 1'b1, 32'h00, 32'h04, 1'b1};
        vt[2]  = '{1'b1, 2'd2, 32'h10, 2'd0, 4'd6, 1'b1, 1'b1, 32'h00, 32'h04, 1'b1};
        vt[3]  = '{1'b1, 2'd2, 32'h18, 2'd0, 4'd8, 1'b1, 1'b1, 32'h00, 32'h04, 1'b0};
        vt[4]  = '{1'b1, 2'd2, 32'h20, 2'd0, 4'd8, 1'b1, 1'b1, 32'h00, 32'h04, 1'b0};
        vt[5]  = '{1'b1, 2'd2, 32'h20, 2'd2, 4'd6, 1'b1, 1'b1, 32'h08, 32'h0C, 1'b1};
        vt[6]  = '{1'b1, 2'd2, 32'h20, 2'd0, 4'd8, 1'b1, 1'b1, 32'h08, 32'h0C, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 32'h00, 2'd2, 4'd6, 1'b1, 1'b1, 32'h10, 32'h14, 1'b1};
        vt[8]  = '{1'b0, 2'd0, 32'h00, 2'd2, 4'd4, 1'b1, 1'b1, 32'h18, 32'h1C, 1'b1};
        vt[9]  = '{1'b0, 2'd0, 32'h00, 2'd1, 4'd3, 1'b1, 1'b1, 32'h1C, 32'h20, 1'b1};
        vt[10] = '{1'b1, 2'd2, 32'h40, 2'd2, 4'd3, 1'b1, 1'b1, 32'h24, 32'h40, 1'b1};
        vt[11] = '{1'b0, 2'd0, 32'h00, 2'd2, 4'd1, 1'b1, 1'b0, 32'h44, 32'h00, 1'b1};
        vt[12] = '{1'b0, 2'd0, 32'h00, 2'd2, 4'd0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1};
        vt[13] = '{1'b1, 2'd1, 32'h48, 2'd0, 4'd1, 1'b1, 1'b0, 32'h48, 32'h00, 1'b1};
        vt[14] = '{1'b1, 2'd1, 32'h4C, 2'd1, 4'd1, 1'b1, 1'b0, 32'h4C, 32'h00, 1'b1};
        vt[15] = '{1'b0, 2'd0, 32'h00, 2'd2, 4'd0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1};

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].v, vt[i].c, vt[i].pc, vt[i].take, 1'b0);
            step();
            chk($sformatf("v%0d_occ", i), 64'(bus.occupancy), 64'(vt[i].occ));
            chk($sformatf("v%0d_v0", i), 64'(bus.out_valid0), 64'(vt[i].v0));
            chk($sformatf("v%0d_v1", i), 64'(bus.out_valid1), 64'(vt[i].v1));
            chk($sformatf("v%0d_rdy", i), 64'(bus.in_ready), 64'(vt[i].rdy));
            if (vt[i].v0) begin
                chk($sformatf("v%0d_pc0", i), 64'(bus.out_pc0), 64'(vt[i].pc0));
                chk($sformatf("v%0d_in0", i), 64'(bus.out_instr0), 64'(vt[i].pc0 ^ K));
            end
            if (vt[i].v1) begin
                chk($sformatf("v%0d_pc1", i), 64'(bus.out_pc1), 64'(vt[i].pc1));
                chk($sformatf("v%0d_in1", i), 64'(bus.out_instr1), 64'(vt[i].pc1 ^ K));
            end
        end

        // alternating enqueue/take across several pointer wraps, no bypass
        nxt = 32'h100;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd2, nxt, 2'd0, 1'b0);
            #1;
            chk("wrap_nobypass", 64'(bus.out_valid0), 64'd0);
            step();
            chk("wrap_pc0", 64'(bus.out_pc0), 64'(nxt));
            chk("wrap_pc1", 64'(bus.out_pc1), 64'(nxt + 32'd4));
            chk("wrap_in1", 64'(bus.out_instr1), 64'((nxt + 32'd4) ^ K));
            drive(1'b0, 2'd0, 32'h0, 2'd2, 1'b0);
            step();
            chk("wrap_occ", 64'(bus.occupancy), 64'd0);
            nxt = nxt + 32'd8;
        end

        // flush beats same-cycle enqueue and dequeue
        drive(1'b1, 2'd2, 32'h200, 2'd0, 1'b0); step();
        drive(1'b1, 2'd2, 32'h208, 2'd0, 1'b0); step();
        drive(1'b1, 2'd1, 32'h210, 2'd0, 1'b0); step();
        chk("fl_pre_occ", 64'(bus.occupancy), 64'd5);
        drive(1'b1, 2'd2, 32'h300, 2'd1, 1'b1);
        step();
        chk("fl_occ", 64'(bus.occupancy), 64'd0);
        chk("fl_v0", 64'(bus.out_valid0), 64'd0);
        drive(1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
        step();
        chk("fl_nostore", 64'(bus.occupancy), 64'd0);
        drive(1'b1, 2'd2, 32'h400, 2'd0, 1'b0);
        step();
        chk("fl_after_pc0", 64'(bus.out_pc0), 64'h400);
        chk("fl_after_pc1", 64'(bus.out_pc1), 64'h404);

        // asynchronous reset mid-operation, then idle stall count
        drive(1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
        rst = 1'b1;
        #2;
        chk("arst_occ", 64'(bus.occupancy), 64'd0);
        chk("arst_v0", 64'(bus.out_valid0), 64'd0);
        chk("arst_rdy", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("stall_cnt", 64'(bus.stall_cycles), 64'(STALL_EXP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
